fpu_sched: RTL

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_sched_pkg.sv | 41 ++++
 rtl/fpu_sched_fifo.sv | 56 +++++
 rtl/fpu_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: unit-index constants, opcode field widths and the func7/func3 decoder.
// Latency: combinational decode only.
// Backpressure: n/a (types and functions only).
package fpu_sched_pkg;

  localparam int LEN_FUNC3 = 3;
  localparam int LEN_FUNC7 = 7;
  // One bit wider than the 8-unit index so ILLEGAL can never collide with a real unit.
  localparam int UNIT_W    = 4;

  localparam logic [UNIT_W-1:0] ADDSUB  = 4'd0;
  localparam logic [UNIT_W-1:0] MUL     = 4'd1;
  localparam logic [UNIT_W-1:0] DIV     = 4'd2;
  localparam logic [UNIT_W-1:0] SQRT    = 4'd3;
  localparam logic [UNIT_W-1:0] SGNJ    = 4'd4;
  localparam logic [UNIT_W-1:0] FLOOR   = 4'd5;
  localparam logic [UNIT_W-1:0] CVT     = 4'd6;
  localparam logic [UNIT_W-1:0] CMP     = 4'd7;
  localparam logic [UNIT_W-1:0] ILLEGAL = 4'hF;

  // RISC-V F-extension func7 encodings; func3 only qualifies the ops where it selects a variant.
  function automatic logic [UNIT_W-1:0] decode(input logic [LEN_FUNC7-1:0] f7,
                                               input logic [LEN_FUNC3-1:0] f3);
    logic [UNIT_W-1:0] u;
    u = ILLEGAL;
    case (f7)
      7'h00, 7'h04: u = ADDSUB;                    // FADD / FSUB
      7'h08:        u = MUL;
      7'h0C:        u = DIV;
      7'h2C:        u = SQRT;
      7'h10:        u = (f3 <= 3'd2) ? SGNJ : ILLEGAL;
      7'h14:        u = (f3 <= 3'd1) ? CMP  : ILLEGAL;  // FMIN / FMAX
      7'h50:        u = (f3 <= 3'd2) ? CMP  : ILLEGAL;  // FEQ / FLT / FLE
      7'h60:        u = FLOOR;                     // float -> int with rounding
      7'h68:        u = CVT;                       // int -> float
      default:      u = ILLEGAL;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_sched_fifo.sv
// fpu_sched_fifo: in-order queue of issued operations (DEPTH entries, WIDTH bits each).
// Latency: head visible combinationally on dout_o the cycle after push.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk/rstn, push_i/din_i, pop_i, dout_o (head), empty_o, full_o.
module fpu_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // When full, the slot being overwritten is the head being popped in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    // Pointers are PW bits wide, so DEPTH being a power of two makes the wrap implicit.
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: issues FP ops to NUNITS sub-units, retires results in issue order with caller tags.
// Latency: result 1 cycle after unit done (same cycle when FPU_SCHED_BYPASS_EN is defined).
// Backpressure: order held off while target unit busy or queue full; results held while res_ready=0.
// Ports: order/accepted + func3/func7/rs1/rs2/tag request; u_* per-unit order/accepted/done/rd;
//        res_valid/res_ready + res_tag/res_rd/res_err retire channel.
// Config macro: FPU_SCHED_BYPASS_EN adds a done-to-result path for the queue head.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int NUNITS = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   order,
  output logic                   accepted,
  input  logic [LEN_FUNC3-1:0]   func3,
  input  logic [LEN_FUNC7-1:0]   func7,
  input  logic [31:0]            rs1,
  input  logic [31:0]            rs2,
  input  logic [TAG_W-1:0]       tag,
  output logic [NUNITS-1:0]      u_order,
  input  logic [NUNITS-1:0]      u_accepted,
  input  logic [NUNITS-1:0]      u_done,
  output logic [LEN_FUNC3-1:0]   u_func3,
  output logic [LEN_FUNC7-1:0]   u_func7,
  output logic [31:0]            u_rs1,
  output logic [31:0]            u_rs2,
  input  logic [NUNITS*32-1:0]   u_rd,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [TAG_W-1:0]       res_tag,
  output logic [31:0]            res_rd,
  output logic                   res_err
);

  localparam int UIDX_W = (NUNITS > 1) ? $clog2(NUNITS) : 1;
  localparam int QW     = UNIT_W + TAG_W;

  logic [NUNITS-1:0] busy_q, busy_d;
  logic [NUNITS-1:0] hold_vld_q, hold_vld_d;
  logic [31:0]       hold_q [NUNITS];
  logic [31:0]       unit_rd [NUNITS];

  logic [UNIT_W-1:0] dec_unit, head_unit;
  logic [UIDX_W-1:0] dec_idx, head_idx;
  logic              dec_ill, head_ill;
  logic [TAG_W-1:0]  head_tag;
  logic [QW-1:0]     q_din, q_dout;
  logic              q_empty, q_full;
  logic              room, order_ok, retire, head_rdy;

  assign u_func3 = func3;
  assign u_func7 = func7;
  assign u_rs1   = rs1;
  assign u_rs2   = rs2;

  always_comb begin
    for (int k = 0; k < NUNITS; k++) unit_rd[k] = u_rd[32*k +: 32];
  end

  // ---------------- issue side ----------------
  assign dec_unit = decode(func7, func3);
  assign dec_ill  = (int'(dec_unit) >= NUNITS);
  assign dec_idx  = dec_unit[UIDX_W-1:0];

  // A retire this cycle frees a slot, so a full queue can still take a new op.
  assign room     = ~q_full | retire;
  assign order_ok = order & rstn & room;

  always_comb begin
    u_order = '0;
    for (int k = 0; k < NUNITS; k++) begin
      u_order[k] = order_ok & ~dec_ill & (dec_idx == UIDX_W'(k)) & ~busy_q[k];
    end
  end

  // Illegal ops never reach a unit; they take a queue slot immediately.
  assign accepted = order_ok & (dec_ill | (u_order[dec_idx] & u_accepted[dec_idx]));
  assign q_din    = {(dec_ill ? ILLEGAL : dec_unit), tag};

  fpu_sched_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (accepted),
    .din_i   (q_din),
    .pop_i   (retire),
    .dout_o  (q_dout),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // ---------------- retire side ----------------
  assign {head_unit, head_tag} = q_dout;
  assign head_ill = (int'(head_unit) >= NUNITS);
  assign head_idx = head_unit[UIDX_W-1:0];

`ifdef FPU_SCHED_BYPASS_EN
  assign head_rdy = hold_vld_q[head_idx] | (u_done[head_idx] & busy_q[head_idx]);
`else
  assign head_rdy = hold_vld_q[head_idx];
`endif

  assign res_valid = ~q_empty & (head_ill | head_rdy);
  assign retire    = res_valid & res_ready;
  assign res_tag   = res_valid ? head_tag : '0;
  assign res_err   = res_valid & head_ill;

  always_comb begin
    res_rd = '0;
    if (res_valid && !head_ill) begin
`ifdef FPU_SCHED_BYPASS_EN
      res_rd = hold_vld_q[head_idx] ? hold_q[head_idx] : unit_rd[head_idx];
`else
      res_rd = hold_q[head_idx];
`endif
    end
  end

  // ---------------- per-unit state ----------------
  always_comb begin
    busy_d     = busy_q;
    hold_vld_d = hold_vld_q;
    for (int k = 0; k < NUNITS; k++) begin
      if (u_order[k] && u_accepted[k]) busy_d[k] = 1'b1;
      // Done from an idle unit (e.g. a pre-reset op finishing late) is dropped.
      if (u_done[k] && busy_q[k]) hold_vld_d[k] = 1'b1;
    end
    // Retire wins over a same-cycle done (bypass case): the result already left.
    if (retire && !head_ill) begin
      busy_d[head_idx]     = 1'b0;
      hold_vld_d[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= '0;
      hold_vld_q <= '0;
      for (int k = 0; k < NUNITS; k++) hold_q[k] <= '0;
    end else begin
      busy_q     <= busy_d;
      hold_vld_q <= hold_vld_d;
      for (int k = 0; k < NUNITS; k++) begin
        if (u_done[k] && busy_q[k]) hold_q[k] <= unit_rd[k];
      end
    end
  end

endmodule
